// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter that shares one synchronous FIFO write port among NUM_REQ producers.
// A grant is held for up to MAX_BURST accepted beats or until the granted producer goes idle.
module fifo_wr_arbiter #(
  parameter  int NUM_REQ    = 4,
  parameter  int DATA_WIDTH = 8,
  parameter  int MAX_BURST  = 4,
  localparam int ID_WIDTH   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_wdata,
  output logic                          grant_valid,
  output logic [ID_WIDTH-1:0]           grant_id
);

  localparam int CNT_WIDTH = $clog2(MAX_BURST) + 1;

  localparam logic [0:0] ST_ARB   = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  logic [0:0]           state_q, state_d;
  logic [ID_WIDTH-1:0]  gnt_idx_q, gnt_idx_d;
  logic [ID_WIDTH-1:0]  last_idx_q, last_idx_d;
  logic [CNT_WIDTH-1:0] beat_cnt_q, beat_cnt_d;

  logic                 pick_found;
  logic [ID_WIDTH-1:0]  pick_idx;
  logic                 in_grant;
  logic                 gnt_req_valid;
  logic                 burst_done;

  function automatic logic [ID_WIDTH-1:0] wrap_idx(input int v);
    return ID_WIDTH'(v % NUM_REQ);
  endfunction

  // Round-robin pick: first valid requester strictly after the last served index.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      if (!pick_found && req_valid[wrap_idx(int'(last_idx_q) + off)]) begin
        pick_found = 1'b1;
        pick_idx   = wrap_idx(int'(last_idx_q) + off);
      end
    end
  end

  assign in_grant      = (state_q == ST_GRANT);
  assign gnt_req_valid = req_valid[gnt_idx_q];
  assign burst_done    = (beat_cnt_q == CNT_WIDTH'(MAX_BURST - 1));

  always_comb begin
    req_ready   = '0;
    fifo_wr_en  = 1'b0;
    fifo_wdata  = '0;
    grant_valid = 1'b0;
    grant_id    = '0;
    if (in_grant) begin
      req_ready[gnt_idx_q] = ~fifo_full;
      fifo_wr_en           = gnt_req_valid & ~fifo_full;
      fifo_wdata           = req_data[gnt_idx_q*DATA_WIDTH +: DATA_WIDTH];
      grant_valid          = 1'b1;
      grant_id             = gnt_idx_q;
    end
  end

  always_comb begin
    state_d    = state_q;
    gnt_idx_d  = gnt_idx_q;
    last_idx_d = last_idx_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      ST_ARB: begin
        if (pick_found) begin
          gnt_idx_d  = pick_idx;
          beat_cnt_d = '0;
          state_d    = ST_GRANT;
        end
      end
      ST_GRANT: begin
        // A full FIFO with valid held is a stall: nothing changes, beats are not counted.
        if (!gnt_req_valid) begin
          state_d    = ST_ARB;
          last_idx_d = gnt_idx_q;
        end else if (fifo_wr_en) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
          if (burst_done) begin
            state_d    = ST_ARB;
            last_idx_d = gnt_idx_q;
          end
        end
      end
      default: state_d = ST_ARB;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset) begin
      state_q    <= ST_ARB;
      gnt_idx_q  <= '0;
      last_idx_q <= ID_WIDTH'(NUM_REQ - 1);
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      gnt_idx_q  <= gnt_idx_d;
      last_idx_q <= last_idx_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed vector table plus FIFO-model sequences (rotation, full stall, random scoreboard)
// for fifo_wr_arbiter with NUM_REQ=4, DATA_WIDTH=8, MAX_BURST=4.
module tb_fifo_wr_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        fifo_full;
  logic        fifo_wr_en;
  logic [7:0]  fifo_wdata;
  logic        grant_valid;
  logic [1:0]  grant_id;

  fifo_wr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .MAX_BURST(4)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en),
    .fifo_wdata(fifo_wdata), .grant_valid(grant_valid), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rst;
    logic [3:0]  v;
    logic [31:0] d;
    logic        full;
    logic        chk;
    logic        gv;
    logic [1:0]  gid;
    logic [3:0]  rdy;
    logic        wen;
    logic [7:0]  wd;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic rst, input logic [3:0] v, input logic [31:0] d, input logic full,
                     input logic chk, input logic gv, input logic [1:0] gid, input logic [3:0] rdy,
                     input logic wen, input logic [7:0] wd);
    vec_t r;
    r.rst = rst; r.v = v; r.d = d; r.full = full; r.chk = chk;
    r.gv = gv; r.gid = gid; r.rdy = rdy; r.wen = wen; r.wd = wd;
    tbl.push_back(r);
  endtask

  // Producer / FIFO model used by the streaming sequences.
  logic [5:0] prod_seq [4];
  logic [5:0] rd_seq   [4];
  logic [3:0] prod_v;
  logic [3:0] active;
  bit         rnd_mode;
  logic [7:0] fq[$];
  int         wr_cnt;
  logic       last_gv;
  logic [3:0] last_rdy;

  task automatic model_reset(input logic [3:0] act, input bit rnd);
    @(negedge clk);
    reset = 1'b1; req_valid = '0; req_data = '0; fifo_full = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    active = act; rnd_mode = rnd; fq.delete(); wr_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      prod_seq[i] = '0; rd_seq[i] = '0; prod_v[i] = act[i];
    end
  endtask

  task automatic pop_check();
    logic [7:0] d;
    d = fq.pop_front();
    check($sformatf("order p%0d", d[7:6]), {26'd0, d[5:0]}, {26'd0, rd_seq[d[7:6]]});
    rd_seq[d[7:6]] = rd_seq[d[7:6]] + 1'b1;
  endtask

  task automatic step(input bit pop, input bit extra_full);
    logic       w;
    logic [7:0] wd;
    logic [3:0] r;
    @(negedge clk);
    req_valid = prod_v;
    for (int i = 0; i < 4; i++) req_data[i*8 +: 8] = {2'(i), prod_seq[i]};
    fifo_full = (fq.size() >= 8) || extra_full;
    #1;
    if (fifo_full) check("no write while full", {31'd0, fifo_wr_en}, 32'd0);
    if ($countones(req_ready) > 1) check("ready onehot", {28'd0, req_ready}, 32'd0);
    w = fifo_wr_en; wd = fifo_wdata; r = req_ready;
    last_gv = grant_valid; last_rdy = req_ready;
    @(posedge clk);
    if (pop && fq.size() > 0) pop_check();
    if (w) begin
      fq.push_back(wd);
      wr_cnt++;
    end
    for (int i = 0; i < 4; i++) begin
      if (r[i] && prod_v[i]) begin
        prod_seq[i] = prod_seq[i] + 1'b1;
        prod_v[i]   = active[i] && (!rnd_mode || ($urandom_range(3) != 0));
      end else if (!prod_v[i]) begin
        prod_v[i] = active[i] && (!rnd_mode || ($urandom_range(1) != 0));
      end
    end
  endtask

  initial begin
    int w0;

    reset = 1'b1; req_valid = '0; req_data = '0; fifo_full = 1'b0;
    repeat (2) @(posedge clk);

    // rst, valid, data, full, chk | gv, gid, ready, wr_en, wdata
    add(1, 4'b0000, 32'h0000_0000, 0, 1, 0, 0, 4'b0000, 0, 8'h00);
    add(0, 4'b0001, 32'h0000_0010, 0, 1, 0, 0, 4'b0000, 0, 8'h00); // ARB bubble
    add(0, 4'b0001, 32'h0000_0010, 0, 1, 1, 0, 4'b0001, 1, 8'h10);
    add(0, 4'b0001, 32'h0000_0011, 0, 1, 1, 0, 4'b0001, 1, 8'h11);
    add(0, 4'b0001, 32'h0000_0012, 0, 1, 1, 0, 4'b0001, 1, 8'h12);
    add(0, 4'b0001, 32'h0000_0013, 0, 1, 1, 0, 4'b0001, 1, 8'h13); // 4th beat ends burst
    add(0, 4'b0001, 32'h0000_0014, 0, 1, 0, 0, 4'b0000, 0, 8'h00);
    add(0, 4'b0000, 32'h0000_0014, 0, 1, 1, 0, 4'b0001, 0, 8'h14); // idle producer releases
    add(0, 4'b0000, 32'h0000_0014, 0, 1, 0, 0, 4'b0000, 0, 8'h00);
    add(1, 4'b0000, 32'h0000_0000, 0, 1, 0, 0, 4'b0000, 0, 8'h00);
    add(0, 4'b0010, 32'h0000_2100, 0, 1, 0, 0, 4'b0000, 0, 8'h00);
    add(0, 4'b0010, 32'h0000_2100, 0, 1, 1, 1, 4'b0010, 1, 8'h21);
    add(0, 4'b0101, 32'h0031_2101, 0, 1, 1, 1, 4'b0010, 0, 8'h21); // last_idx becomes 1
    add(0, 4'b0101, 32'h0031_2101, 0, 1, 0, 0, 4'b0000, 0, 8'h00);
    add(0, 4'b0101, 32'h0031_2101, 0, 1, 1, 2, 4'b0100, 1, 8'h31); // 2 wins over 0
    add(0, 4'b0101, 32'h0032_2101, 0, 1, 1, 2, 4'b0100, 1, 8'h32);
    add(0, 4'b0001, 32'h0032_2101, 0, 1, 1, 2, 4'b0100, 0, 8'h32); // drop after 2 beats
    add(0, 4'b0001, 32'h0032_2101, 0, 1, 0, 0, 4'b0000, 0, 8'h00);
    add(0, 4'b0001, 32'h0032_2101, 0, 1, 1, 0, 4'b0001, 1, 8'h01);
    add(1, 4'b0000, 32'h0032_2101, 0, 0, 0, 0, 4'b0000, 0, 8'h00);
    add(0, 4'b0010, 32'h0000_4101, 0, 1, 0, 0, 4'b0000, 0, 8'h00);
    add(0, 4'b0010, 32'h0000_4101, 0, 1, 1, 1, 4'b0010, 1, 8'h41);
    add(0, 4'b0010, 32'h0000_4201, 0, 1, 1, 1, 4'b0010, 1, 8'h42);
    add(1, 4'b0011, 32'h0000_4302, 0, 0, 0, 0, 4'b0000, 0, 8'h00); // reset mid-burst
    add(0, 4'b0011, 32'h0000_4302, 0, 1, 0, 0, 4'b0000, 0, 8'h00);
    add(0, 4'b0011, 32'h0000_4302, 0, 1, 1, 0, 4'b0001, 1, 8'h02); // lowest valid after reset
    add(0, 4'b0011, 32'h0000_4303, 1, 1, 1, 0, 4'b0000, 0, 8'h03); // stall
    add(0, 4'b0011, 32'h0000_4303, 0, 1, 1, 0, 4'b0001, 1, 8'h03);
    add(0, 4'b0011, 32'h0000_4304, 0, 1, 1, 0, 4'b0001, 1, 8'h04);
    add(0, 4'b0011, 32'h0000_4305, 0, 1, 1, 0, 4'b0001, 1, 8'h05); // stall was not counted
    add(0, 4'b0011, 32'h0000_4306, 0, 1, 0, 0, 4'b0000, 0, 8'h00);
    add(0, 4'b0011, 32'h0000_4306, 0, 1, 1, 1, 4'b0010, 1, 8'h43);

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      reset = tbl[i].rst; req_valid = tbl[i].v; req_data = tbl[i].d; fifo_full = tbl[i].full;
      #1;
      if (tbl[i].chk) begin
        check($sformatf("row%0d grant_valid", i), {31'd0, grant_valid}, {31'd0, tbl[i].gv});
        check($sformatf("row%0d grant_id", i),    {30'd0, grant_id},    {30'd0, tbl[i].gid});
        check($sformatf("row%0d req_ready", i),   {28'd0, req_ready},   {28'd0, tbl[i].rdy});
        check($sformatf("row%0d fifo_wr_en", i),  {31'd0, fifo_wr_en},  {31'd0, tbl[i].wen});
        check($sformatf("row%0d fifo_wdata", i),  {24'd0, fifo_wdata},  {24'd0, tbl[i].wd});
      end
    end

    // All producers valid: grants rotate 0,1,2,3,0 with 4 beats each and a bubble between.
    @(negedge clk);
    reset = 1'b1; req_valid = '0; fifo_full = 1'b0;
    @(negedge clk);
    reset = 1'b0; req_valid = 4'b1111; req_data = 32'hA3A2_A1A0;
    #1;
    for (int g = 0; g < 5; g++) begin
      check($sformatf("rot%0d bubble gv", g), {31'd0, grant_valid}, 32'd0);
      check($sformatf("rot%0d bubble ready", g), {28'd0, req_ready}, 32'd0);
      for (int b = 0; b < 4; b++) begin
        @(negedge clk); #1;
        check($sformatf("rot%0d.%0d grant_id", g, b), {30'd0, grant_id}, 32'(g % 4));
        check($sformatf("rot%0d.%0d ready", g, b), {28'd0, req_ready}, 32'(1 << (g % 4)));
        check($sformatf("rot%0d.%0d wr_en", g, b), {31'd0, fifo_wr_en}, 32'd1);
        check($sformatf("rot%0d.%0d wdata", g, b), {24'd0, fifo_wdata}, 32'hA0 + 32'(g % 4));
      end
      @(negedge clk); #1;
    end

    // Depth-8 FIFO with no reads: exactly 8 writes, then a held stall.
    model_reset(4'b0011, 1'b0);
    for (int c = 0; c < 30; c++) step(1'b0, 1'b0);
    check("full writes", 32'(wr_cnt), 32'd8);
    check("full stall gv", {31'd0, last_gv}, 32'd1);
    check("full stall ready", {28'd0, last_rdy}, 32'd0);
    for (int k = 1; k <= 4; k++) begin
      step(1'b1, 1'b0);
      w0 = wr_cnt;
      step(1'b0, 1'b0);
      check($sformatf("pop%0d one write", k), 32'(wr_cnt - w0), 32'd1);
      step(1'b0, 1'b0);
      check($sformatf("pop%0d grant held", k), {31'd0, last_gv}, (k < 4) ? 32'd1 : 32'd0);
    end
    while (fq.size() > 0) pop_check();

    // Random valid/full traffic against the FIFO scoreboard.
    model_reset(4'b1111, 1'b1);
    for (int c = 0; c < 1000; c++) step($urandom_range(1) != 0, $urandom_range(7) == 0);
    while (fq.size() > 0) pop_check();
    for (int i = 0; i < 4; i++)
      check($sformatf("rand count p%0d", i), {26'd0, rd_seq[i]}, {26'd0, prod_seq[i]});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Shares the single write port of the team's synchronous FIFO (wr_en/full/wdata) among NUM_REQ producers.
- Uses round-robin arbitration with burst hold: a granted producer keeps the port for up to MAX_BURST accepted beats, or until it deasserts valid.
- Sits directly in front of the FIFO write side. The FIFO read side is untouched.

Parameters:
- NUM_REQ, 4, number of producers (2..8).
- DATA_WIDTH, 8, word width; must match the FIFO DATA_WIDTH.
- MAX_BURST, 4, maximum accepted beats per grant (1..16).
- ID_WIDTH, derived localparam = max(1, clog2(NUM_REQ)); not overridable.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  NUM_REQ  per-producer data valid.
- req_data  input  NUM_REQ*DATA_WIDTH  producer i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready  output  NUM_REQ  per-producer accept; one-hot or zero.
- fifo_full  input  1  from FIFO full.
- fifo_wr_en  output  1  to FIFO wr_en.
- fifo_wdata  output  DATA_WIDTH  to FIFO wdata.
- grant_valid  output  1  a grant is held this cycle.
- grant_id  output  ID_WIDTH  index of the granted producer.

Behaviour:
- State machine: ARB and GRANT. Registers: state, gnt_idx, last_idx, beat_cnt (clog2(MAX_BURST)+1 bits).
- Reset (synchronous, overrides everything, including mid-burst):
  - state=ARB, last_idx=NUM_REQ-1, beat_cnt=0, gnt_idx=0.
  - All outputs deassert: req_ready=0, fifo_wr_en=0, grant_valid=0, grant_id=0, fifo_wdata=0.
  - The first grant after reset therefore goes to the lowest-index requester.
- ARB:
  - If no req_valid bit is set, stay in ARB.
  - Otherwise pick the first set bit scanning last_idx+1, last_idx+2, ... modulo NUM_REQ.
  - Load gnt_idx with that index, clear beat_cnt, go to GRANT.
  - No data moves in ARB: req_ready=0, fifo_wr_en=0.
  - This gives one bubble cycle per grant.
- GRANT outputs (combinational from registers and current inputs):
  - grant_valid=1, grant_id=gnt_idx.
  - req_ready[gnt_idx] = ~fifo_full; all other ready bits = 0.
  - fifo_wr_en = req_valid[gnt_idx] & ~fifo_full.
  - fifo_wdata = req_data slice gnt_idx. Zero when not in GRANT.
- Beat accepted = fifo_wr_en=1. On acceptance, beat_cnt increments.
- GRANT exits (to ARB, with last_idx<=gnt_idx):
  - (a) a beat is accepted and beat_cnt==MAX_BURST-1 (burst limit reached), or
  - (b) req_valid[gnt_idx]=0 (producer idle; no beat that cycle).
- fifo_full=1 in GRANT while req_valid[gnt_idx]=1:
  - Stall: no write, beat_cnt holds, grant is held.
  - Stalled cycles do not count toward MAX_BURST.
- Producer protocol: valid/ready. A producer must hold valid and data stable until ready. Valid may only drop after an accepted beat.
- Non-granted producers see ready=0 and are never written.
- Simultaneous limit-reached and other requesters valid: exit to ARB; round-robin moves past the just-served index.
- Zero-latency write path: a beat accepted at edge N is in the FIFO at edge N (same edge as the FIFO's own wr_en sample).
- Single requester continuously valid: bursts of MAX_BURST beats separated by one ARB cycle, so throughput is MAX_BURST/(MAX_BURST+1).
- The block never writes when fifo_full=1, so FIFO overflow is impossible by construction.

Test Plan:
- Reset, then req_valid=4'b0001, data 8'h10..8'h13 → grant_id=0 one cycle after valid; fifo_wr_en high for exactly 4 consecutive cycles writing 10,11,12,13; then one ARB cycle; grant_valid low.
- All four producers valid continuously, MAX_BURST=4 → grant order 0,1,2,3,0; each grant writes exactly 4 beats; ARB bubble between grants; req_ready always one-hot or zero.
- Producer 2 valid for only 2 beats while producer 0 is valid → grant 2 releases on valid drop after 2 beats; next grant goes to 3 if valid, else 0 (round-robin from last_idx=2).
- FIFO depth 8 (ADDR_WIDTH=3) with no reads, producers 0 and 1 streaming → exactly 8 writes, then fifo_full=1 and req_ready=0 with the grant held; popping 1 word allows exactly 1 more write; beat_cnt is unchanged across the stall.
- Reset asserted mid-burst (after 2 beats of grant 1) → next edge: grant_valid=0, req_ready=0, fifo_wr_en=0; after release, the first grant goes to the lowest valid index.
- Scoreboard over 1000 random valid/full cycles → per-producer FIFO read order matches each producer's send order; no write ever occurs while fifo_full=1.
